// File: rtl/coeff_loader_if.sv
// Host-to-loader field stream plus the loader's coefficient-memory write port.
// master: host/observer side; slave: the loader itself.
interface coeff_loader_if #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned AW         = 7,
  parameter int unsigned WORD_WIDTH = 24
);
  logic                  valid;
  logic                  ready;
  logic [DATA_W-1:0]     data;
  logic                  ce;
  logic                  we;
  logic [AW-1:0]         a;
  logic [WORD_WIDTH-1:0] d;

  modport master (
    output valid, data,
    input  ready, ce, we, a, d
  );

  modport slave (
    input  valid, data,
    output ready, ce, we, a, d
  );
endinterface

// File: rtl/coeff_loader.sv
// Packs a field-serial node stream into 24-bit tree-node words and writes
// one word per node across all channels, rejecting nodes with a bad one_pos.
module coeff_loader #(
  parameter int unsigned FEATURES        = 3,
  parameter int unsigned COEFF_BIT_DEPTH = 4,
  parameter int unsigned BIAS_BIT_DEPTH  = 10,
  parameter int unsigned MAX_CLUSTERS    = 5,
  parameter int unsigned CHANNEL_COUNT   = 16,
  parameter int unsigned WORD_WIDTH      = 24,
  parameter int unsigned DATA_W          = 10,
  localparam int unsigned AW             = $clog2(MAX_CLUSTERS*CHANNEL_COUNT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  coeff_loader_if.slave bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] err_addr
);

  localparam int unsigned PACK_W = 2 + FEATURES + (FEATURES-1)*COEFF_BIT_DEPTH + BIAS_BIT_DEPTH;
  localparam int unsigned DEPTH  = MAX_CLUSTERS*CHANNEL_COUNT;
  localparam int unsigned FW     = $clog2(FEATURES+2);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);
  localparam logic [FW-1:0] BIAS_IDX  = FW'(FEATURES+1);

  typedef enum logic [1:0] {IDLE, FIELD, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [PACK_W-1:0]   shadow_q, shadow_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [FW-1:0]       field_q, field_d;
  logic                err_d;
  logic [AW-1:0]       err_addr_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_ce_q, mem_ce_d;
  logic                mem_we_q, mem_we_d;
  logic [AW-1:0]       mem_a_q, mem_a_d;
  logic [WORD_WIDTH-1:0] mem_d_q, mem_d_d;
  logic                busy_d, done_d;
  logic                node_ok;
  int unsigned         coeff_lsb;

  function automatic logic is_onehot(input logic [FEATURES-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      addr_q     <= '0;
      field_q    <= '0;
      err        <= 1'b0;
      err_addr   <= '0;
      in_ready_q <= 1'b0;
      mem_ce_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_d_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      addr_q     <= addr_d;
      field_q    <= field_d;
      err        <= err_d;
      err_addr   <= err_addr_d;
      in_ready_q <= in_ready_d;
      mem_ce_q   <= mem_ce_d;
      mem_we_q   <= mem_we_d;
      mem_a_q    <= mem_a_d;
      mem_d_q    <= mem_d_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next state, shadow packing and next output values.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    addr_d     = addr_q;
    field_d    = field_q;
    err_d      = err;
    err_addr_d = err_addr;
    node_ok    = is_onehot(shadow_q[PACK_W-3 -: FEATURES]);
    coeff_lsb  = BIAS_BIT_DEPTH + (FEATURES - 32'(field_q)) * COEFF_BIT_DEPTH;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FIELD;
          addr_d     = '0;
          field_d    = '0;
          err_d      = 1'b0;
          err_addr_d = '0;
        end
      end
      FIELD: begin
        if (bus.valid && in_ready_q) begin
          if (field_q == '0)
            shadow_d[PACK_W-1 -: 2] = bus.data[1:0];
          else if (field_q == FW'(1))
            shadow_d[PACK_W-3 -: FEATURES] = bus.data[FEATURES-1:0];
          else if (field_q == BIAS_IDX)
            shadow_d[BIAS_BIT_DEPTH-1:0] = bus.data[BIAS_BIT_DEPTH-1:0];
          else
            shadow_d[coeff_lsb +: COEFF_BIT_DEPTH] = bus.data[COEFF_BIT_DEPTH-1:0];

          if (field_q == BIAS_IDX) state_d = WRITE;
          else                     field_d = field_q + FW'(1);
        end
      end
      WRITE: begin
        // A rejected node is skipped: the address advances regardless.
        if (!node_ok && !err) begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
        end
        addr_d  = addr_q + AW'(1);
        field_d = '0;
        state_d = (addr_q == LAST_ADDR) ? DONE : FIELD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == FIELD);
    mem_ce_d   = (state_d == WRITE);
    mem_we_d   = (state_d == WRITE) && is_onehot(shadow_d[PACK_W-3 -: FEATURES]);
    mem_a_d    = (state_d == WRITE) ? addr_d : '0;
    mem_d_d    = (state_d == WRITE) ? WORD_WIDTH'(shadow_d) : '0;
    busy_d     = (state_d == FIELD) || (state_d == WRITE);
    done_d     = (state_d == DONE);
  end

  assign bus.ready = in_ready_q;
  assign bus.ce    = mem_ce_q;
  assign bus.we    = mem_we_q;
  assign bus.a     = mem_a_q;
  assign bus.d     = mem_d_q;

endmodule

// File: tb/tb_coeff_loader.sv
// Randomized scoreboard bench for coeff_loader against a field-level packing model.
module tb_coeff_loader;
  localparam int unsigned AW    = 7;
  localparam int unsigned DEPTH = 80;

  logic clk = 1'b0;
  logic reset, start;
  logic busy, done, err;
  logic [AW-1:0] err_addr;

  coeff_loader_if #(.DATA_W(10), .AW(AW), .WORD_WIDTH(24)) bif ();

  coeff_loader dut (
    .clk(clk), .reset(reset), .start(start), .bus(bif),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic        we;
    logic [23:0] data;
    logic        first_err;
  } exp_t;

  exp_t sb[$];
  int tests = 0, fails = 0;
  int cyc = 0, done_cnt = 0, last_ce_cyc = 0, last_ce_addr = -1;
  int gap_pct = 0;
  bit chk_err_next = 0;
  int exp_err_next_addr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference packing: fields concatenated MSB-first, 23 bits used of 24.
  function automatic logic [23:0] pack(input int f[5]);
    longint w;
    w = f[0] & 3;
    w = (w << 3)  | (f[1] & 7);
    w = (w << 4)  | (f[2] & 15);
    w = (w << 4)  | (f[3] & 15);
    w = (w << 10) | (f[4] & 1023);
    return w[23:0];
  endfunction

  task automatic send_field(input int unsigned v, input int unsigned w);
    int t = 0;
    int unsigned m = (1 << w) - 1;
    while ($urandom_range(99) < gap_pct) begin
      bif.valid = 1'b0;
      bif.data  = 10'($urandom);
      @(negedge clk);
    end
    bif.valid = 1'b1;
    bif.data  = 10'((v & m) | ($urandom & ~m));
    while (!bif.ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bif.ready) begin
      fails++; tests++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    @(negedge clk);
  endtask

  function automatic void gen_node(input int kind, input int a, output int f[5]);
    f[0] = $urandom_range(3);
    f[1] = 1 << $urandom_range(2);
    f[2] = $urandom_range(15);
    f[3] = $urandom_range(15);
    f[4] = $urandom_range(1023);
    case (kind)
      0: begin
        if (a == 0) f = '{3, 4, 5, 10, 'h155};
        if (a == 7) f[1] = 6;
        if (a == 9) f[1] = 0;
      end
      1: if ($urandom_range(9) == 0) f[1] = $urandom_range(7);
      3: if (a == 5) f[1] = 3;
      default: ;
    endcase
  endfunction

  task automatic send_node(input int kind, input int a, inout bit seen_err, inout int first_addr);
    int f[5];
    int wd[5] = '{2, 3, 4, 4, 10};
    exp_t e;
    gen_node(kind, a, f);
    e.addr = a;
    e.we   = ($countones(f[1]) == 1);
    e.data = (kind == 0 && a == 0) ? 24'h716955 : pack(f);
    e.first_err = !e.we && !seen_err;
    if (e.first_err) begin seen_err = 1; first_addr = a; end
    sb.push_back(e);
    for (int i = 0; i < 5; i++) send_field(f[i], wd[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_cleared_on_start", err, 0);
  endtask

  task automatic full_load(input int kind);
    bit seen_err = 0;
    int first_addr = 0;
    int dc0 = done_cnt;
    int t = 0;
    pulse_start();
    for (int a = 0; a < DEPTH; a++) begin
      if (kind == 1 && a == 30) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_node(kind, a, seen_err, first_addr);
    end
    bif.valid = 1'b0;
    while (done_cnt == dc0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - dc0, 1);
    chk("err_final", err, seen_err);
    chk("err_addr_final", err_addr, seen_err ? first_addr : 0);
    chk("busy_after_done", busy, 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, bif.ready, 0);
    chk({tag, "_ce"}, bif.ce, 0);
    chk({tag, "_we"}, bif.we, 0);
    chk({tag, "_a"}, bif.a, 0);
    chk({tag, "_d"}, bif.d, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_addr"}, err_addr, 0);
  endtask

  // Monitor: pops the scoreboard on every write strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_err_next) begin
        chk_err_next = 0;
        chk("err_set_after_write", err, 1);
        chk("err_addr_captured", err_addr, exp_err_next_addr);
      end
      if (!reset) begin
        if (bif.ce) begin
          if (sb.size() == 0) begin
            fails++; tests++;
            $display("FAIL unexpected_write actual addr=%0d required=none", bif.a);
          end else begin
            e = sb.pop_front();
            chk("wr_addr", bif.a, e.addr);
            chk("wr_we", bif.we, e.we);
            chk("wr_data", bif.d, e.data);
            chk("ready_low_in_write", bif.ready, 0);
            if (e.first_err) begin
              chk("err_low_during_first_bad", err, 0);
              chk_err_next = 1;
              exp_err_next_addr = e.addr;
            end
          end
          last_ce_cyc  = cyc;
          last_ce_addr = bif.a;
        end else begin
          chk("idle_bus_zero", {bif.we, bif.d}, 0);
        end
        if (done) begin
          done_cnt++;
          chk("done_latency", cyc - last_ce_cyc, 1);
          chk("done_last_addr", last_ce_addr, DEPTH - 1);
          chk("busy_low_at_done", busy, 0);
        end
      end
    end
  end

  initial begin
    bit seen_err = 0;
    int first_addr = 0;
    int f[5];
    reset = 1'b1; start = 1'b0;
    bif.valid = 1'b0; bif.data = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    gap_pct = 0;  full_load(0);
    gap_pct = 30; full_load(1);

    // Abort mid-node with reset, then reload cleanly.
    gap_pct = 20;
    pulse_start();
    for (int a = 0; a < 12; a++) send_node(3, a, seen_err, first_addr);
    gen_node(2, 12, f);
    send_field(f[0], 2);
    send_field(f[1], 3);
    send_field(f[2], 4);
    bif.valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_empty_after_abort", sb.size(), 0);
    chk("no_write_after_abort", last_ce_addr, 11);

    gap_pct = 10; full_load(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule

// File: doc/coeff_loader.md
Name: coeff_loader

Overview:
- Writer side of the per-channel decision-tree coefficient memory that the tree traversal controller reads.
- Accepts a field-serial stream of node parameters over a valid/ready handshake and packs each node into one 24-bit word using the controller's layout.
- Writes one packed word per node to the memory port, covering all nodes for all channels, and validates each node's one-position field.
- Sits between the host/config interface and the coefficient memory; runs once per table load, before sorting starts.

Parameters:
- FEATURES, 3, features per node; gives FEATURES-1 stored coefficients.
- COEFF_BIT_DEPTH, 4, width of each stored coefficient.
- BIAS_BIT_DEPTH, 10, width of the bias field.
- MAX_CLUSTERS, 5, node words per channel.
- CHANNEL_COUNT, 16, number of channels.
- WORD_WIDTH, 24, memory word width; must be >= 2+FEATURES+(FEATURES-1)*COEFF_BIT_DEPTH+BIAS_BIT_DEPTH.
- DATA_W, 10, input field width; must be >= max(BIAS_BIT_DEPTH, COEFF_BIT_DEPTH, FEATURES, 2).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a full-table load
- in_valid  input  1  in_data holds a field
- in_ready  output  1  loader accepts a field this cycle
- in_data  input  DATA_W  field value, LSB-aligned; upper bits ignored
- mem_ce  output  1  memory chip enable
- mem_we  output  1  memory write enable
- mem_a  output  clog2(MAX_CLUSTERS*CHANNEL_COUNT)  write address
- mem_d  output  WORD_WIDTH  packed write data
- busy  output  1  load in progress
- done  output  1  one-cycle pulse; load complete
- err  output  1  sticky; a node failed validation
- err_addr  output  clog2(MAX_CLUSTERS*CHANNEL_COUNT)  address of the first failing node

Behaviour:
- Reset: all outputs 0 (in_ready, mem_ce, mem_we, mem_a, mem_d, busy, done, err, err_addr); state IDLE; field and address counters 0.
- Reset mid-load aborts the load immediately; no further writes occur.

States:
- IDLE: waits for start. On start, go to FIELD; clear address, field index and err/err_addr; set busy. start is ignored whenever busy=1.
- FIELD: in_ready=1. A field is accepted when in_valid & in_ready. Per-node field order (FEATURES+2 fields):
  - 0: child flags, 2 bits
  - 1: one_pos, FEATURES bits
  - 2 .. FEATURES: coeff[0 .. FEATURES-2], COEFF_BIT_DEPTH bits each
  - FEATURES+1: bias, BIAS_BIT_DEPTH bits
  - Each accepted field goes into a word shadow register. Accepting the bias field moves to WRITE.
- WRITE (one cycle): in_ready=0; mem_ce=1; mem_a = current address; mem_d = shadow.
  - mem_we=1 only if one_pos has exactly one bit set.
  - Otherwise mem_we=0; if err=0, set err=1 and capture err_addr.
  - The address always increments, so a rejected node is skipped, not retried.
  - If the address equals MAX_CLUSTERS*CHANNEL_COUNT-1, go to DONE; else go to FIELD with field index 0.
- DONE (one cycle): done=1, busy=0 from this cycle; go to IDLE.

Word packing, MSB-first from bit 2+FEATURES+(FEATURES-1)*COEFF_BIT_DEPTH+BIAS_BIT_DEPTH-1 (22 with defaults):
- flags[1:0], then one_pos, then coeff[0], coeff[1], ..., then bias at [BIAS_BIT_DEPTH-1:0].
- Unused MSBs (bit 23 with defaults) are written as 0.
- Address order is linear: a = ch*MAX_CLUSTERS + node, node fastest.

Timing and outputs:
- Latency: write strobe occurs exactly 1 cycle after the bias field is accepted.
- Minimum period per node: FEATURES+3 cycles.
- mem_ce and mem_d are 0 outside WRITE.
- in_valid with in_ready=0 is not consumed; the source holds the data.

Test Plan:
- Reset, then start. Node 0 fields 2'b11, 3'b100, 4'h5, 4'hA, 10'h155 -> one cycle after the bias is accepted: mem_we=1, mem_a=0, mem_d=24'h716955.
- Full load of 80 valid nodes with in_valid held high -> exactly 80 write strobes at addresses 0..79 in order; done pulses once, 1 cycle after the address-79 write; busy falls with done; err=0.
- Node at address 7 with one_pos=3'b110, node 9 with one_pos=3'b000 -> no write at 7 or 9; err=1 from the cycle after node 7's WRITE; err_addr=7; all other addresses written.
- Random in_valid gaps, plus in_valid held high during WRITE -> the field held during WRITE is not lost; it becomes field 0 of the next node; packed words match the reference model.
- Assert start while busy at address 30 -> ignored; the load completes normally at address 79.
- Assert reset after 3 fields of node 12 -> outputs 0 next cycle; no write to address 12. A new start then writes from address 0, and err is cleared.
